// File: rtl/control_multiciclo.sv
// ---------------------------------------------------------------------------
// control_multiciclo
// Multi-cycle MIPS-subset controller. Steps each instruction through
// FETCH / DECODE / execute / memory / write-back states and drives the
// datapath strobes for the current step. Supports R-type (add, sub, and,
// or, slt), addi, lw, sw and beq; anything else parks the controller in
// TRAP until reset.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   run      in   level; 1 = leave IDLE and keep fetching, 0 = halt at the
//                 next instruction boundary
//   opcode   in   [5:0] instruction bits 31:26, used in DECODE
//   funct    in   [5:0] instruction bits 5:0, used in DECODE
//   zf       in   ALU zero flag, used in BRANCH
//   pc_en    out  PC write
//   ir_en    out  instruction register load
//   br       out  register-bank write enable
//   regdst   out  1 = rd, 0 = rt
//   mem_rd   out  memory read strobe
//   mem_wr   out  memory write strobe
//   alusrc   out  1 = sign-extended immediate as ALU operand B
//   memtoreg out  1 = memory data to register bank
//   pc_src   out  1 = branch target to PC
//   aluop    out  [2:0] ALU operation
//   busy     out  controller not in IDLE
//   illegal  out  sticky bad-instruction flag
//   retired  out  [15:0] completed-instruction count (wraps)
// ---------------------------------------------------------------------------
module control_multiciclo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zf,
    output logic        pc_en,
    output logic        ir_en,
    output logic        br,
    output logic        regdst,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        alusrc,
    output logic        memtoreg,
    output logic        pc_src,
    output logic [2:0]  aluop,
    output logic        busy,
    output logic        illegal,
    output logic [15:0] retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        WB_R,
        WB_MEM,
        BRANCH,
        TRAP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  op_q;
    logic [5:0]  funct_q;
    logic [15:0] retired_q;
    logic        illegal_q;
    logic        complete;

    // R-type funct field to ALU operation.
    function automatic logic [2:0] alu_r(input logic [5:0] f);
        case (f)
            6'b100000: alu_r = ALU_ADD;
            6'b100010: alu_r = ALU_SUB;
            6'b100100: alu_r = ALU_AND;
            6'b100101: alu_r = ALU_OR;
            6'b101010: alu_r = ALU_SLT;
            default:   alu_r = ALU_AND;
        endcase
    endfunction

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010: funct_ok = 1'b1;
            default:              funct_ok = 1'b0;
        endcase
    endfunction

    // The four states that finish an instruction.
    assign complete = (state == WB_R) || (state == WB_MEM) ||
                      (state == MEM_WR) || (state == BRANCH);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction fields are latched while leaving DECODE; later states
    // (EXEC_R, MEM_ADDR, WB_R) work from this copy, not the live inputs.
    always_ff @(posedge clk) begin
        if (state == DECODE) begin
            op_q    <= opcode;
            funct_q <= funct;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            if (complete) begin
                retired_q <= retired_q + 16'd1;
            end
            if (state_next == TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (run) state_next = FETCH;
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = funct_ok(funct) ? EXEC_R : TRAP;
                    OP_ADDI:      state_next = EXEC_I;
                    OP_LW, OP_SW: state_next = MEM_ADDR;
                    OP_BEQ:       state_next = BRANCH;
                    default:      state_next = TRAP;
                endcase
            end
            EXEC_R:   state_next = WB_R;
            EXEC_I:   state_next = WB_R;
            MEM_ADDR: state_next = (op_q == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   state_next = WB_MEM;
            WB_R, WB_MEM, MEM_WR, BRANCH:
                      state_next = run ? FETCH : IDLE;
            TRAP:     state_next = TRAP;
            default:  state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pc_en    = 1'b0;
        ir_en    = 1'b0;
        br       = 1'b0;
        regdst   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        pc_src   = 1'b0;
        aluop    = 3'b000;
        case (state)
            FETCH: begin
                mem_rd = 1'b1;
                ir_en  = 1'b1;
                pc_en  = 1'b1;
                aluop  = ALU_ADD;
            end
            EXEC_R: begin
                aluop = alu_r(funct_q);
            end
            EXEC_I, MEM_ADDR: begin
                alusrc = 1'b1;
                aluop  = ALU_ADD;
            end
            WB_R: begin
                br     = 1'b1;
                regdst = (op_q == OP_RTYPE);
            end
            MEM_RD: begin
                mem_rd = 1'b1;
            end
            WB_MEM: begin
                br       = 1'b1;
                memtoreg = 1'b1;
            end
            MEM_WR: begin
                mem_wr = 1'b1;
            end
            BRANCH: begin
                aluop  = ALU_SUB;
                pc_en  = zf;
                pc_src = zf;
            end
            default: begin
            end
        endcase
    end

    assign busy    = (state != IDLE);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_control_multiciclo
// Directed-vector bench for control_multiciclo. Inputs change on the falling
// edge; outputs are sampled on the falling edge, so each sample reflects the
// state entered at the preceding rising edge. Outputs are compared as one
// packed vector:
//   {pc_en, ir_en, br, regdst, mem_rd, mem_wr, alusrc, memtoreg, pc_src,
//    aluop[2:0], busy}
// ---------------------------------------------------------------------------
module tb_control_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zf;
    logic        pc_en, ir_en, br, regdst, mem_rd, mem_wr;
    logic        alusrc, memtoreg, pc_src, busy, illegal;
    logic [2:0]  aluop;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    localparam logic [12:0] S_IDLE    = 13'b0_0_0_0_0_0_0_0_0_000_0;
    localparam logic [12:0] S_FETCH   = 13'b1_1_0_0_1_0_0_0_0_010_1;
    localparam logic [12:0] S_DEC     = 13'b0_0_0_0_0_0_0_0_0_000_1;
    localparam logic [12:0] S_EXR_ADD = 13'b0_0_0_0_0_0_0_0_0_010_1;
    localparam logic [12:0] S_WBR_R   = 13'b0_0_1_1_0_0_0_0_0_000_1;
    localparam logic [12:0] S_EXI     = 13'b0_0_0_0_0_0_1_0_0_010_1;
    localparam logic [12:0] S_WBR_I   = 13'b0_0_1_0_0_0_0_0_0_000_1;
    localparam logic [12:0] S_MRD     = 13'b0_0_0_0_1_0_0_0_0_000_1;
    localparam logic [12:0] S_WBM     = 13'b0_0_1_0_0_0_0_1_0_000_1;
    localparam logic [12:0] S_MWR     = 13'b0_0_0_0_0_1_0_0_0_000_1;
    localparam logic [12:0] S_BR_T    = 13'b1_0_0_0_0_0_0_0_1_110_1;
    localparam logic [12:0] S_BR_N    = 13'b0_0_0_0_0_0_0_0_0_110_1;
    localparam logic [12:0] S_TRAP    = 13'b0_0_0_0_0_0_0_0_0_000_1;

    control_multiciclo dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .opcode   (opcode),
        .funct    (funct),
        .zf       (zf),
        .pc_en    (pc_en),
        .ir_en    (ir_en),
        .br       (br),
        .regdst   (regdst),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .alusrc   (alusrc),
        .memtoreg (memtoreg),
        .pc_src   (pc_src),
        .aluop    (aluop),
        .busy     (busy),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] outs();
        return {pc_en, ir_en, br, regdst, mem_rd, mem_wr, alusrc,
                memtoreg, pc_src, aluop, busy};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; opcode = 6'b111111; funct = 6'b000001; zf = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== S_IDLE || retired !== 16'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset: outs=%b retired=%h illegal=%b, expected %b 0000 0",
                     outs(), retired, illegal, S_IDLE);
        end
        run = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== S_IDLE) begin
            errors++;
            $display("FAIL idle_hold: outs=%b expected %b", outs(), S_IDLE);
        end
    endtask

    task automatic test_rtype_add();
        logic [12:0] exp [4];
        logic [15:0] r0;
        exp = '{S_FETCH, S_DEC, S_EXR_ADD, S_WBR_R};
        r0 = retired;
        opcode = 6'b000000; funct = 6'b100000; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL rtype_add step%0d: outs=%b expected %b", i, outs(), exp[i]);
            end
            if (i == 3) run = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (retired !== r0 + 16'd1 || outs() !== S_IDLE) begin
            errors++;
            $display("FAIL rtype_add retire: retired=%h outs=%b expected %h %b",
                     retired, outs(), r0 + 16'd1, S_IDLE);
        end
    endtask

    task automatic test_alu_map();
        logic [5:0] fn [5];
        logic [2:0] op [5];
        logic [15:0] r0;
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        op = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int k = 0; k < 5; k++) begin
            r0 = retired;
            opcode = 6'b000000; funct = fn[k]; run = 1'b1;
            repeat (3) @(negedge clk);
            checks++;
            if (outs() !== {9'b0, op[k], 1'b1}) begin
                errors++;
                $display("FAIL alu_map funct=%b: outs=%b expected %b", fn[k], outs(), {9'b0, op[k], 1'b1});
            end
            run = 1'b0;
            repeat (2) @(negedge clk);
            checks++;
            if (retired !== r0 + 16'd1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL alu_map retire funct=%b: retired=%h busy=%b expected %h 0",
                         fn[k], retired, busy, r0 + 16'd1);
            end
        end
    endtask

    task automatic test_lw();
        logic [12:0] exp [5];
        logic [15:0] r0;
        exp = '{S_FETCH, S_DEC, S_EXI, S_MRD, S_WBM};
        r0 = retired;
        opcode = 6'b100011; funct = 6'b000000; run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL lw step%0d: outs=%b expected %b", i, outs(), exp[i]);
            end
            if (i == 4) run = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (retired !== r0 + 16'd1 || outs() !== S_IDLE) begin
            errors++;
            $display("FAIL lw retire: retired=%h outs=%b expected %h %b",
                     retired, outs(), r0 + 16'd1, S_IDLE);
        end
    endtask

    task automatic test_sw();
        logic [12:0] exp [4];
        logic [15:0] r0;
        exp = '{S_FETCH, S_DEC, S_EXI, S_MWR};
        r0 = retired;
        opcode = 6'b101011; funct = 6'b100000; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL sw step%0d: outs=%b expected %b", i, outs(), exp[i]);
            end
            if (i == 3) run = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (retired !== r0 + 16'd1 || outs() !== S_IDLE) begin
            errors++;
            $display("FAIL sw retire: retired=%h outs=%b expected %h %b",
                     retired, outs(), r0 + 16'd1, S_IDLE);
        end
    endtask

    task automatic test_beq(input logic z);
        logic [12:0] exp [3];
        logic [15:0] r0;
        exp = '{S_FETCH, S_DEC, z ? S_BR_T : S_BR_N};
        r0 = retired;
        opcode = 6'b000100; funct = 6'b000000; zf = z; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL beq zf=%b step%0d: outs=%b expected %b", z, i, outs(), exp[i]);
            end
            if (i == 2) run = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (retired !== r0 + 16'd1 || outs() !== S_IDLE) begin
            errors++;
            $display("FAIL beq zf=%b retire: retired=%h outs=%b expected %h %b",
                     z, retired, outs(), r0 + 16'd1, S_IDLE);
        end
        zf = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp [7];
        logic [15:0] r0;
        exp = '{S_FETCH, S_DEC, S_EXI, S_WBR_I, S_FETCH, S_DEC, S_BR_N};
        r0 = retired;
        opcode = 6'b001000; funct = 6'b111111; zf = 1'b0; run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL back_to_back step%0d: outs=%b expected %b", i, outs(), exp[i]);
            end
            if (i == 4) opcode = 6'b000100;
            if (i == 6) run = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (retired !== r0 + 16'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back retire: retired=%h busy=%b expected %h 0",
                     retired, busy, r0 + 16'd2);
        end
    endtask

    task automatic test_run_drop();
        logic [15:0] r0;
        r0 = retired;
        opcode = 6'b000000; funct = 6'b100010; run = 1'b1;
        repeat (3) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== S_WBR_R) begin
            errors++;
            $display("FAIL run_drop wb: outs=%b expected %b", outs(), S_WBR_R);
        end
        @(negedge clk);
        checks++;
        if (outs() !== S_IDLE || retired !== r0 + 16'd1) begin
            errors++;
            $display("FAIL run_drop idle: outs=%b retired=%h expected %b %h",
                     outs(), retired, S_IDLE, r0 + 16'd1);
        end
    endtask

    task automatic test_wrap();
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        @(negedge clk);
        checks++;
        if (retired !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap preset: retired=%h expected ffff", retired);
        end
        opcode = 6'b001000; funct = 6'b000000; run = 1'b1;
        repeat (3) @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (retired !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap: retired=%h busy=%b expected 0000 0", retired, busy);
        end
    endtask

    task automatic test_trap(input logic [5:0] op, input logic [5:0] fn);
        logic [15:0] r0;
        r0 = retired;
        opcode = op; funct = fn; run = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run = i[0];
            checks++;
            if (outs() !== S_TRAP || illegal !== 1'b1 || retired !== r0) begin
                errors++;
                $display("FAIL trap op=%b fn=%b cyc%0d: outs=%b illegal=%b retired=%h expected %b 1 %h",
                         op, fn, i, outs(), illegal, retired, S_TRAP, r0);
            end
        end
        run = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (outs() !== S_IDLE || illegal !== 1'b0 || retired !== 16'd0) begin
            errors++;
            $display("FAIL trap reset: outs=%b illegal=%b retired=%h expected %b 0 0000",
                     outs(), illegal, retired, S_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011; funct = 6'b000000; run = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b0;
        checks++;
        if (outs() !== S_IDLE || retired !== 16'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: outs=%b retired=%h illegal=%b expected %b 0000 0",
                     outs(), retired, illegal, S_IDLE);
        end
        @(negedge clk);
        checks++;
        if (outs() !== S_IDLE) begin
            errors++;
            $display("FAIL reset_mid hold: outs=%b expected %b", outs(), S_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_alu_map();
        test_lw();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_back_to_back();
        test_run_drop();
        test_wrap();
        test_trap(6'b111111, 6'b100000);
        test_trap(6'b000000, 6'b000001);
        test_rtype_add();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
